// File: rtl/mpi_link_pkg.sv
// Shared types and constants for the MPI credit link.
// Used by both sender and receiver endpoints.
package mpi_link_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } snd_state_e;

  localparam logic TAG_VALID = 1'b0;
  localparam logic TAG_YUMI  = 1'b1;

  localparam int LINK_DATA_W = 64;

endpackage

// File: rtl/mpi_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, registered count.
// Push while full and pop while empty are ignored.
module mpi_sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mpi_credit_sender.sv
// Credit-managed transmit endpoint of the MPI valid/yumi link.
// One word in flight; next word may launch on the yumi edge.
module mpi_credit_sender
  import mpi_link_pkg::*;
#(
  parameter int DATA_W  = LINK_DATA_W,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic [31:0]                  dest,
  output logic                         valid,
  output logic [DATA_W-1:0]            data_out,
  output logic [31:0]                  dest_q,
  output logic                         ready_snd,
  input  logic                         yumi,
  input  logic                         credit_ret,
  output logic [$clog2(CREDITS+1)-1:0] credits,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  snd_state_e        state;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              done;
  logic              ovf;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign done     = (state != S_IDLE) && yumi;

  // A same-edge credit return only counts on the completion path.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      S_IDLE:  pop = !empty && (credits != '0);
      default: pop = done && !empty &&
                     ((credits != '0) || credit_ret);
    endcase
  end

  assign ovf = credit_ret && !pop && (credits == CMAX);

  mpi_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      valid     <= 1'b0;
      ready_snd <= 1'b0;
      data_out  <= '0;
      dest_q    <= '0;
      credits   <= CMAX;
      err       <= 1'b0;
    end else begin
      ready_snd <= pop;
      if (pop) begin
        data_out <= head;
        dest_q   <= dest;
      end
      unique case ({credit_ret, pop})
        2'b10:   if (!ovf) credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
      if (ovf || (state == S_IDLE && yumi)) err <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_LAUNCH;
            valid <= 1'b1;
          end
        end
        default: begin
          if (pop) begin
            state <= S_LAUNCH;
            valid <= 1'b1;
          end else if (yumi) begin
            state <= S_IDLE;
            valid <= 1'b0;
          end else begin
            state <= S_WAIT;
            valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpi_credit_sender.sv
// Directed bench for mpi_credit_sender.
// Inputs change and outputs are sampled on the falling edge.
module tb_mpi_credit_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic [31:0] dest;
  logic        valid;
  logic [63:0] data_out;
  logic [31:0] dest_q;
  logic        ready_snd;
  logic        yumi;
  logic        credit_ret;
  logic [2:0]  credits;
  logic [2:0]  fifo_count;
  logic        err;

  int total = 0;
  int pass  = 0;

  logic [63:0] lq_data[$];
  int          lq_cyc[$];

  always #5 clk = ~clk;

  mpi_credit_sender #(
    .DATA_W  (64),
    .DEPTH   (4),
    .CREDITS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .dest       (dest),
    .valid      (valid),
    .data_out   (data_out),
    .dest_q     (dest_q),
    .ready_snd  (ready_snd),
    .yumi       (yumi),
    .credit_ret (credit_ret),
    .credits    (credits),
    .fifo_count (fifo_count),
    .err        (err)
  );

  task automatic do_reset();
    in_valid   = 1'b0;
    in_data    = '0;
    dest       = '0;
    yumi       = 1'b0;
    credit_ret = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pushes n words, acks every valid word, records each launch.
  task automatic stream(input int n, input logic [63:0] base,
                        input int cycles, input bit ret);
    int sent = 0;
    lq_data.delete();
    lq_cyc.delete();
    for (int c = 0; c < cycles; c++) begin
      if (ready_snd) begin
        lq_data.push_back(data_out);
        lq_cyc.push_back(c);
      end
      yumi       = valid;
      credit_ret = ret && valid;
      if (sent < n && in_ready) begin
        in_valid = 1'b1;
        in_data  = base + 64'(sent);
        dest     = 32'(sent);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    yumi       = 1'b0;
    credit_ret = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    dest       = '0;
    yumi       = 1'b0;
    credit_ret = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (valid !== 1'b0)
      $display("FAIL rst_valid: got %0h want 0", valid);
    else pass++;
    total++;
    if (ready_snd !== 1'b0)
      $display("FAIL rst_ready_snd: got %0h want 0", ready_snd);
    else pass++;
    total++;
    if (data_out !== 64'h0 || dest_q !== 32'h0)
      $display("FAIL rst_data: got %0h/%0h want 0/0",
               data_out, dest_q);
    else pass++;
    total++;
    if (credits !== 3'd4)
      $display("FAIL rst_credits: got %0d want 4", credits);
    else pass++;
    total++;
    if (fifo_count !== 3'd0 || err !== 1'b0)
      $display("FAIL rst_count_err: got %0d/%0h want 0/0",
               fifo_count, err);
    else pass++;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_in_ready: got %0h want 1", in_ready);
    else pass++;
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1;
    in_data  = 64'hA5;
    dest     = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (fifo_count !== 3'd1 || valid !== 1'b0)
      $display("FAIL single_n: got cnt %0d v %0h want 1/0",
               fifo_count, valid);
    else pass++;
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || ready_snd !== 1'b1)
      $display("FAIL single_launch: got v %0h r %0h want 1/1",
               valid, ready_snd);
    else pass++;
    total++;
    if (data_out !== 64'hA5 || dest_q !== 32'd7)
      $display("FAIL single_data: got %0h/%0d want a5/7",
               data_out, dest_q);
    else pass++;
    total++;
    if (credits !== 3'd3 || fifo_count !== 3'd0)
      $display("FAIL single_credit: got %0d/%0d want 3/0",
               credits, fifo_count);
    else pass++;
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    total++;
    if (valid !== 1'b0 || ready_snd !== 1'b0)
      $display("FAIL single_done: got v %0h r %0h want 0/0",
               valid, ready_snd);
    else pass++;
    total++;
    if (err !== 1'b0 || credits !== 3'd3)
      $display("FAIL single_err: got %0h/%0d want 0/3",
               err, credits);
    else pass++;
  endtask

  task automatic test_credit_stall();
    do_reset();
    stream(6, 64'h100, 20, 1'b0);
    total++;
    if (lq_data.size() !== 4)
      $display("FAIL stall_launches: got %0d want 4",
               lq_data.size());
    else pass++;
    for (int k = 0; k < lq_data.size(); k++) begin
      total++;
      if (lq_data[k] !== 64'h100 + 64'(k))
        $display("FAIL stall_data%0d: got %0h want %0h",
                 k, lq_data[k], 64'h100 + 64'(k));
      else pass++;
    end
    total++;
    if (credits !== 3'd0 || fifo_count !== 3'd2 || valid !== 1'b0)
      $display("FAIL stall_state: got c%0d n%0d v%0h want 0/2/0",
               credits, fifo_count, valid);
    else pass++;
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    total++;
    if (credits !== 3'd1 || valid !== 1'b0)
      $display("FAIL stall_ret: got c%0d v%0h want 1/0",
               credits, valid);
    else pass++;
    @(negedge clk);
    total++;
    if (ready_snd !== 1'b1 || data_out !== 64'h104 ||
        credits !== 3'd0 || fifo_count !== 3'd1)
      $display("FAIL stall_fifth: got r%0h %0h c%0d n%0d want 1/104/0/1",
               ready_snd, data_out, credits, fifo_count);
    else pass++;
    yumi       = 1'b1;
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    total++;
    if (ready_snd !== 1'b1 || data_out !== 64'h105 ||
        credits !== 3'd0)
      $display("FAIL stall_sameedge: got r%0h %0h c%0d want 1/105/0",
               ready_snd, data_out, credits);
    else pass++;
    @(negedge clk);
    yumi = 1'b0;
    total++;
    if (valid !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL stall_end: got v%0h n%0d want 0/0",
               valid, fifo_count);
    else pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    stream(4, 64'h200, 12, 1'b0);
    total++;
    if (lq_data.size() !== 4)
      $display("FAIL b2b_count: got %0d want 4", lq_data.size());
    else pass++;
    for (int k = 0; k < lq_data.size(); k++) begin
      total++;
      if (lq_data[k] !== 64'h200 + 64'(k) ||
          lq_cyc[k] !== lq_cyc[0] + k)
        $display("FAIL b2b_w%0d: got %0h@%0d want %0h@%0d",
                 k, lq_data[k], lq_cyc[k],
                 64'h200 + 64'(k), lq_cyc[0] + k);
      else pass++;
    end
    total++;
    if (credits !== 3'd0 || valid !== 1'b0)
      $display("FAIL b2b_end: got c%0d v%0h want 0/0",
               credits, valid);
    else pass++;
  endtask

  task automatic test_credit_edge();
    do_reset();
    stream(3, 64'h400, 12, 1'b0);
    total++;
    if (credits !== 3'd1)
      $display("FAIL edge_pre: got %0d want 1", credits);
    else pass++;
    in_valid = 1'b1;
    in_data  = 64'h4AA;
    @(negedge clk);
    in_valid   = 1'b0;
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    total++;
    if (credits !== 3'd1 || ready_snd !== 1'b1 ||
        data_out !== 64'h4AA)
      $display("FAIL edge_retpop: got c%0d r%0h %0h want 1/1/4aa",
               credits, ready_snd, data_out);
    else pass++;
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      credit_ret = 1'b1;
      @(negedge clk);
    end
    credit_ret = 1'b0;
    total++;
    if (credits !== 3'd4 || err !== 1'b0)
      $display("FAIL edge_full: got c%0d e%0h want 4/0",
               credits, err);
    else pass++;
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    total++;
    if (credits !== 3'd4 || err !== 1'b1)
      $display("FAIL edge_ovf: got c%0d e%0h want 4/1",
               credits, err);
    else pass++;
  endtask

  task automatic test_fifo_wrap();
    do_reset();
    stream(4, 64'h280, 12, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h300 + 64'(i);
      @(negedge clk);
    end
    total++;
    if (in_ready !== 1'b0 || fifo_count !== 3'd4)
      $display("FAIL wrap_full: got rdy%0h n%0d want 0/4",
               in_ready, fifo_count);
    else pass++;
    in_data = 64'h3FF;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (fifo_count !== 3'd4 || valid !== 1'b0)
      $display("FAIL wrap_refuse: got n%0d v%0h want 4/0",
               fifo_count, valid);
    else pass++;
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    stream(4, 64'h304, 20, 1'b1);
    total++;
    if (lq_data.size() !== 8)
      $display("FAIL wrap_count: got %0d want 8", lq_data.size());
    else pass++;
    for (int k = 0; k < lq_data.size(); k++) begin
      total++;
      if (lq_data[k] !== 64'h300 + 64'(k))
        $display("FAIL wrap_w%0d: got %0h want %0h",
                 k, lq_data[k], 64'h300 + 64'(k));
      else pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h500 + 64'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || ready_snd !== 1'b0 ||
        fifo_count !== 3'd1 || err !== 1'b1)
      $display("FAIL mid_wait: got v%0h r%0h n%0d e%0h want 1/0/1/1",
               valid, ready_snd, fifo_count, err);
    else pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (valid !== 1'b0 || fifo_count !== 3'd0 ||
        credits !== 3'd4 || err !== 1'b0)
      $display("FAIL mid_rst: got v%0h n%0d c%0d e%0h want 0/0/4/0",
               valid, fifo_count, credits, err);
    else pass++;
    total++;
    if (in_ready !== 1'b1 || data_out !== 64'h0)
      $display("FAIL mid_rst_out: got rdy%0h %0h want 1/0",
               in_ready, data_out);
    else pass++;
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    total++;
    if (err !== 1'b1 || valid !== 1'b0)
      $display("FAIL idle_yumi: got e%0h v%0h want 1/0",
               err, valid);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_stall();
    test_back_to_back();
    test_credit_edge();
    test_fifo_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
